// File: rtl/seg7_display_reader.sv
// seg7_display_reader: monitors a multiplexed, active-low seven-segment bus,
// debounces each digit slot and decodes the lit glyph back to a hex nibble.
// A slot is captured once per stable run, when the same {an, seg} sample has
// been seen STABLE_CYCLES times in a row with exactly one anode enabled.
module seg7_display_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     an,
  input  logic [6:0]            seg,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  update,
  output logic                  code_err
);

  localparam int          SW     = DIGITS + 7;
  localparam logic [7:0]  STABLE = 8'(STABLE_CYCLES);

  logic [DIGITS-1:0]   an_s1_q, an_s2_q;
  logic [6:0]          seg_s1_q, seg_s2_q;
  logic [SW-1:0]       sample;
  logic [SW-1:0]       prev_q;
  logic [7:0]          cnt_q, cnt_d;
  logic [3:0]          low_cnt;
  logic                one_low;
  logic                capture;
  logic [4:0]          dec;
  logic                blank;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic                upd_q, upd_d;
  logic                err_q, err_d;

  // Map a lit abcdefg pattern to {legal, nibble}; legal=0 for anything else.
  function automatic logic [4:0] decode(input logic [6:0] lit);
    case (lit)
      7'b1111110: decode = 5'h10;
      7'b0110000: decode = 5'h11;
      7'b1101101: decode = 5'h12;
      7'b1111001: decode = 5'h13;
      7'b0110011: decode = 5'h14;
      7'b1011011: decode = 5'h15;
      7'b1011111: decode = 5'h16;
      7'b1110000: decode = 5'h17;
      7'b1111111: decode = 5'h18;
      7'b1111011: decode = 5'h19;
      7'b1110111: decode = 5'h1A;
      7'b0011111: decode = 5'h1B;
      7'b1001110: decode = 5'h1C;
      7'b0111101: decode = 5'h1D;
      7'b1001111: decode = 5'h1E;
      7'b1000111: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  // Two-flop synchronizer; reset to all-ones so nothing appears lit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_s1_q  <= '1;
      an_s2_q  <= '1;
      seg_s1_q <= '1;
      seg_s2_q <= '1;
    end else begin
      an_s1_q  <= an;
      an_s2_q  <= an_s1_q;
      seg_s1_q <= seg;
      seg_s2_q <= seg_s1_q;
    end
  end

  // Sample is {anodes, lit segments}; any bit change restarts the run.
  assign sample = {an_s2_q, ~seg_s2_q};
  assign dec    = decode(~seg_s2_q);
  assign blank  = (seg_s2_q == 7'h7F);

  // Run counter and capture decision; capture fires on the 1st reach of STABLE.
  always_comb begin
    low_cnt = '0;
    for (int i = 0; i < DIGITS; i++) begin
      low_cnt = low_cnt + {3'b000, ~an_s2_q[i]};
    end
    one_low = (low_cnt == 4'd1);
    if (!one_low) begin
      cnt_d = '0;
    end else if (sample == prev_q) begin
      cnt_d = (cnt_q == STABLE) ? cnt_q : cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd1;
    end
    capture = one_low && (cnt_d == STABLE) && (cnt_q != STABLE);
  end

  // Output next-state: only the single enabled slot is touched by a capture.
  always_comb begin
    value_d = value_q;
    valid_d = valid_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;
    if (capture) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (!an_s2_q[i]) begin
          if (dec[4]) begin
            value_d[4*i +: 4] = dec[3:0];
            valid_d[i]        = 1'b1;
          end else begin
            valid_d[i] = 1'b0;
          end
        end
      end
      upd_d = dec[4];
      err_d = !dec[4] && !blank;
    end
  end

  // Run state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q  <= {{DIGITS{1'b1}}, 7'b0000000};
      cnt_q   <= '0;
      value_q <= '0;
      valid_q <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= sample;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  assign value       = value_q;
  assign digit_valid = valid_q;
  assign update      = upd_q;
  assign code_err    = err_q;

endmodule

// File: tb/tb_seg7_display_reader.sv
// Directed bench for seg7_display_reader with DIGITS=4, STABLE_CYCLES=8.
module tb_seg7_display_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  an_drv = 4'hF;
  logic [6:0]  seg_drv = 7'h7F;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        update;
  logic        code_err;

  int checks   = 0;
  int failures = 0;
  int both_cnt = 0;

  // Lit abcdefg pattern for each hex digit.
  logic [6:0] glyph [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  seg7_display_reader #(.DIGITS(4), .STABLE_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .an(an_drv), .seg(seg_drv),
    .value(value), .digit_valid(digit_valid),
    .update(update), .code_err(code_err));

  always #5 clk = ~clk;

  // Drive pins at a falling edge, then observe n rising edges (1 = first
  // edge that samples the new pins).
  task automatic hold(input logic [3:0] a, input logic [6:0] lit, input int n,
                      output int n_upd, output int n_err, output int first_edge);
    n_upd = 0; n_err = 0; first_edge = 0;
    @(negedge clk);
    an_drv  = a;
    seg_drv = ~lit;
    for (int e = 1; e <= n; e++) begin
      @(posedge clk); #1;
      if (update) begin
        n_upd++;
        if (first_edge == 0) first_edge = e;
      end
      if (code_err) n_err++;
      if (update && code_err) both_cnt++;
    end
  endtask

  task automatic test_reset();
    int u, r, f;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      an_drv  = 4'($urandom_range(0, 15));
      seg_drv = 7'($urandom_range(0, 127));
    end
    #1;
    checks++; if (value !== 16'h0000) begin failures++; $display("FAIL reset_value got=%h exp=0000", value); end
    checks++; if (digit_valid !== 4'h0) begin failures++; $display("FAIL reset_valid got=%b exp=0000", digit_valid); end
    checks++; if (update !== 1'b0) begin failures++; $display("FAIL reset_update got=%b exp=0", update); end
    checks++; if (code_err !== 1'b0) begin failures++; $display("FAIL reset_code_err got=%b exp=0", code_err); end
    @(negedge clk); rst = 1'b1;
    hold(4'b1111, 7'h7F, 20, u, r, f);  // raw seg=0000000, no anode enabled
    checks++; if (u !== 0) begin failures++; $display("FAIL idle_update got=%0d exp=0", u); end
    checks++; if (r !== 0) begin failures++; $display("FAIL idle_code_err got=%0d exp=0", r); end
  endtask

  task automatic test_single();
    int u, r, f;
    hold(4'b1101, 7'b1111001, 12, u, r, f);
    checks++; if (u !== 1) begin failures++; $display("FAIL single_count got=%0d exp=1", u); end
    checks++; if (f !== 10) begin failures++; $display("FAIL single_edge got=%0d exp=10", f); end
    checks++; if (value !== 16'h0030) begin failures++; $display("FAIL single_value got=%h exp=0030", value); end
    checks++; if (digit_valid !== 4'b0010) begin failures++; $display("FAIL single_valid got=%b exp=0010", digit_valid); end
  endtask

  task automatic test_glitch();
    int u1, u2, r, f;
    hold(4'b1110, glyph[5], 5, u1, r, f);
    hold(4'b1110, glyph[6], 12, u2, r, f);
    checks++; if (u1 + u2 !== 1) begin failures++; $display("FAIL glitch_count got=%0d exp=1", u1 + u2); end
    checks++; if (f !== 10) begin failures++; $display("FAIL glitch_edge got=%0d exp=10", f); end
    checks++; if (value !== 16'h0036) begin failures++; $display("FAIL glitch_value got=%h exp=0036", value); end
  endtask

  task automatic test_illegal();
    int u, r, f;
    hold(4'b1110, 7'b1010101, 12, u, r, f);
    checks++; if (r !== 1 || u !== 0) begin failures++; $display("FAIL illegal_pulses got err=%0d upd=%0d exp err=1 upd=0", r, u); end
    checks++; if (digit_valid !== 4'b0010) begin failures++; $display("FAIL illegal_valid got=%b exp=0010", digit_valid); end
    checks++; if (value !== 16'h0036) begin failures++; $display("FAIL illegal_hold got=%h exp=0036", value); end
    hold(4'b1110, glyph[10], 12, u, r, f);
    checks++; if (value !== 16'h003A || digit_valid !== 4'b0011) begin failures++; $display("FAIL recapture got=%h/%b exp=003A/0011", value, digit_valid); end
    hold(4'b1110, 7'b0000000, 12, u, r, f);
    checks++; if (u !== 0 || r !== 0) begin failures++; $display("FAIL blank_pulses got upd=%0d err=%0d exp 0/0", u, r); end
    checks++; if (value !== 16'h003A || digit_valid !== 4'b0010) begin failures++; $display("FAIL blank_state got=%h/%b exp=003A/0010", value, digit_valid); end
    hold(4'b1100, glyph[8], 12, u, r, f);
    checks++; if (u !== 0 || r !== 0) begin failures++; $display("FAIL multi_pulses got upd=%0d err=%0d exp 0/0", u, r); end
    checks++; if (value !== 16'h003A || digit_valid !== 4'b0010) begin failures++; $display("FAIL multi_state got=%h/%b exp=003A/0010", value, digit_valid); end
  endtask

  task automatic test_scan();
    int u, r, f, tot_u, tot_r;
    logic [3:0] digs [4] = '{4'hF, 4'h3, 4'h2, 4'h1};  // index = slot
    tot_u = 0; tot_r = 0;
    for (int rnd = 0; rnd < 2; rnd++) begin
      for (int s = 3; s >= 0; s--) begin
        hold(~(4'b0001 << s), glyph[digs[s]], 16, u, r, f);
        tot_u += u; tot_r += r;
        checks++; if (u !== 1) begin failures++; $display("FAIL scan_visit slot=%0d got=%0d exp=1", s, u); end
      end
    end
    checks++; if (tot_r !== 0) begin failures++; $display("FAIL scan_err got=%0d exp=0", tot_r); end
    checks++; if (value !== 16'h123F) begin failures++; $display("FAIL scan_value got=%h exp=123F", value); end
    checks++; if (digit_valid !== 4'b1111) begin failures++; $display("FAIL scan_valid got=%b exp=1111", digit_valid); end
  endtask

  task automatic test_back_to_back();
    int u, r, f, tot_u;
    tot_u = 0;
    for (int s = 0; s < 4; s++) begin
      hold(~(4'b0001 << s), glyph[4 + s], 8, u, r, f);
      tot_u += u;
    end
    hold(4'b1111, 7'b0000000, 4, u, r, f);  // last slot lands here
    tot_u += u;
    checks++; if (tot_u !== 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", tot_u); end
    checks++; if (value !== 16'h7654) begin failures++; $display("FAIL b2b_value got=%h exp=7654", value); end
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL pulse_exclusive got=%0d exp=0", both_cnt); end
  endtask

  task automatic test_mid_reset();
    int u, r, f;
    hold(4'b1011, glyph[9], 5, u, r, f);
    checks++; if (u !== 0) begin failures++; $display("FAIL midrst_early got=%0d exp=0", u); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (value !== 16'h0000 || digit_valid !== 4'h0) begin failures++; $display("FAIL midrst_clear got=%h/%b exp=0000/0000", value, digit_valid); end
    checks++; if (update !== 1'b0 || code_err !== 1'b0) begin failures++; $display("FAIL midrst_pulses got=%b%b exp=00", update, code_err); end
    @(negedge clk); rst = 1'b1;
    // One edge passes between release and the start of hold, so the 10th
    // edge after release is hold's 9th.
    hold(4'b1011, glyph[9], 14, u, r, f);
    checks++; if (u !== 1 || f !== 9) begin failures++; $display("FAIL midrst_recapture got cnt=%0d edge=%0d exp 1/9", u, f); end
    checks++; if (value !== 16'h0900 || digit_valid !== 4'b0100) begin failures++; $display("FAIL midrst_state got=%h/%b exp=0900/0100", value, digit_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_illegal();
    test_scan();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_display_reader.md
# seg7_display_reader

Receive-side monitor for a multiplexed, active-low seven-segment display bus. Samples the anode-enable and segment lines, debounces each digit slot, decodes the lit glyph back to a 4-bit hex nibble, and presents the assembled multi-digit value with per-digit validity. Used for board self-test and loopback checks of the display path: it converts what is driven onto the LED pins back into counter values.

## Interface

Parameters:
- DIGITS, 4, number of multiplexed digit slots (legal 1..8)
- STABLE_CYCLES, 8, consecutive identical samples required before a capture (legal 2..255)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- an  in  DIGITS  anode enables, active-low; an[i]=0 selects slot i
- seg  in  7  segment lines, active-low; seg[6]=a, seg[5]=b, seg[4]=c, seg[3]=d, seg[2]=e, seg[1]=f, seg[0]=g
- value  out  4*DIGITS  decoded nibbles; slot i occupies value[4i+3:4i]
- digit_valid  out  DIGITS  bit i=1 when slot i's last capture was a legal hex glyph
- update  out  1  one-cycle pulse on every capture of a legal glyph
- code_err  out  1  one-cycle pulse on every capture of an illegal, non-blank pattern

## Operation

- Input conditioning: an and seg pass through a 2-flop synchronizer; reset value all-ones (nothing lit).
- Sample = {synchronized an, inverted seg (1 = segment lit)}.
- Run counter: increments when the current sample equals the previous sample; loads 1 when it differs; saturates at STABLE_CYCLES.
- Capture qualifies only if an has exactly one bit low. Zero or multiple low bits: counter held at 0, no capture, outputs unchanged.
- Capture fires once per run, on the cycle the counter reaches STABLE_CYCLES. No re-capture until the sample changes.
- Decode table, lit pattern abcdefg: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Legal glyph: write the nibble to slot i, set digit_valid[i], pulse update.
- Blank (0000000): clear digit_valid[i], hold nibble, no pulse.
- Any other pattern: clear digit_valid[i], hold nibble, pulse code_err.
- Other slots are never modified by a capture.

## Timing

- Reset (async assert, sync release): value=0, digit_valid=0, update=0, code_err=0, run counter=0, synchronizers all-ones.
- Latency: if pins change and then hold, the outputs update at the (STABLE_CYCLES+2)th rising edge, counting the first edge that samples the new pin values.
- update and code_err are high for exactly one cycle per capture and are mutually exclusive.
- A pin change at any point before capture restarts the run. No partial credit.
- Reset asserted mid-run aborts the run immediately and clears all outputs. A capture after release needs a full fresh run.
- Back-to-back slots (scan switching each STABLE_CYCLES+k cycles, k≥0) are each captured once.

## Test plan

- Reset: hold rst=0 with random pins -> value=0, digit_valid=0, update=0, code_err=0. Release, then hold an=1111, seg=0000000 for 20 cycles -> no update, no code_err.
- Single capture: STABLE_CYCLES=8, an=1101, seg=~1111001 held 12 cycles -> update pulses once at edge 10, value[7:4]=3, digit_valid=0010, no further pulses.
- Glitch rejection: an=1110 with glyph 5 held 5 cycles, then glyph 6 held 12 cycles -> exactly one update, value[3:0]=6. Glyph 5 is never captured.
- Illegal, blank and multi-anode: after a valid capture on slot 0, seg=~1010101 held 12 cycles -> code_err pulses once, digit_valid[0]=0, nibble held. Blank -> no pulse, digit_valid[0]=0. an=1100 with a legal glyph -> no capture.
- Scan: slots 3..0 show 1,2,3,F, 16 cycles each, repeating -> value=16'h123F, digit_valid=1111, one update per slot visit.
- Mid-run reset: pulse rst low at cycle 5 of a run -> all outputs 0. After release, the capture occurs only after a full new run of STABLE_CYCLES+2 edges.
